// File: rtl/j_busgnt_pkg.sv
// Shared types and constants for the Jerry DSP bus request/grant path.
package j_bus_pkg;

    // Sequencer states, from first request through bus turnaround
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAITFREE,
        S_OWN,
        S_RELEASE
    } j_bus_state_t;

    // Highest bus priority; exempt from the tenure limit
    localparam logic [1:0] J_PRIO_TOP = 2'b00;

endpackage

// File: rtl/j_busgnt_bgcount.sv
// Saturating up-counter with synchronous clear, count enable and a
// terminal flag that is high once the count reaches TERM.
module j_bgcount #(
    parameter int unsigned W    = 4,
    parameter int unsigned TERM = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    localparam logic [W-1:0] TERM_W = TERM[W-1:0];

    logic [W-1:0] r_cnt;

    // Count register: clear wins over enable, holds at all-ones
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_term = (r_cnt >= TERM_W);

endmodule

// File: rtl/j_busgnt.sv
// Bus request/grant sequencer in front of the DSP memory controller.
// Optional feature macro: J_BUSGNT_TENURE_EN (tenure-limited ownership
// for non-top-priority requests).
module j_busgnt
    import j_bus_pkg::*;
#(
    parameter int unsigned IDLE_HOLD  = 4,
    parameter int unsigned MAX_TENURE = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mreq,
    input  logic       dreql,
    input  logic       ack,
    input  logic [1:0] dbrls,
    input  logic       bgl,
    input  logic       bbusyl,
    output logic       brl,
    output logic       bgackl,
    output logic       dbgl,
    output logic       owner
);

    j_bus_state_t r_state;
    j_bus_state_t w_next;

    logic w_own_entry;
    logic w_idle_clr;
    logic w_idle_term;
    logic w_ten_rel;

    assign w_own_entry = (r_state == S_WAITFREE) && bbusyl;
    assign w_idle_clr  = w_own_entry || ack || mreq || !dreql;

    j_bgcount #(
        .W    (4),
        .TERM (IDLE_HOLD - 1)
    ) u_idle_cnt (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_clr  (w_idle_clr),
        .i_en   (1'b1),
        .o_term (w_idle_term)
    );

`ifdef J_BUSGNT_TENURE_EN
    logic w_ten_term;

    j_bgcount #(
        .W    (8),
        .TERM (MAX_TENURE - 1)
    ) u_tenure_cnt (
        .i_clk  (clk),
        .i_rst  (reset),
        .i_clr  (w_own_entry),
        .i_en   (r_state == S_OWN),
        .o_term (w_ten_term)
    );

    assign w_ten_rel = w_ten_term && (dbrls != J_PRIO_TOP);
`else
    logic w_unused;
    assign w_unused  = ^dbrls;
    assign w_ten_rel = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a release from OWN waits for the controller to be quiet
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mreq || !dreql) w_next = S_REQ;
            end
            S_REQ: begin
                if (!bgl)                 w_next = S_WAITFREE;
                else if (!mreq && dreql)  w_next = S_IDLE;
            end
            S_WAITFREE: begin
                if (bbusyl) w_next = S_OWN;
            end
            S_OWN: begin
                if (dreql && ((w_idle_term && !mreq) || bgl || w_ten_rel))
                    w_next = S_RELEASE;
            end
            S_RELEASE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Moore output decode from the state register only
    always_comb begin
        brl    = 1'b1;
        bgackl = 1'b1;
        dbgl   = 1'b1;
        owner  = 1'b0;
        case (r_state)
            S_REQ, S_WAITFREE: begin
                brl = 1'b0;
            end
            S_OWN: begin
                brl    = 1'b0;
                bgackl = 1'b0;
                dbgl   = 1'b0;
                owner  = 1'b1;
            end
            S_RELEASE: begin
                bgackl = 1'b0;
            end
            default: begin
                brl = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_j_busgnt.sv
// Directed bench for j_busgnt; outputs compared as {brl,bgackl,dbgl,owner}.
module tb_j_busgnt;

    logic       clk = 1'b0;
    logic       reset;
    logic       mreq;
    logic       dreql;
    logic       ack;
    logic [1:0] dbrls;
    logic       bgl;
    logic       bbusyl;
    logic       brl;
    logic       bgackl;
    logic       dbgl;
    logic       owner;

    int total = 0;
    int bad   = 0;

    // expected output vectors {brl,bgackl,dbgl,owner}
    localparam logic [3:0] O_IDLE = 4'b1110;
    localparam logic [3:0] O_REQ  = 4'b0110;
    localparam logic [3:0] O_OWN  = 4'b0001;
    localparam logic [3:0] O_REL  = 4'b1010;

    logic [3:0] outs;
    assign outs = {brl, bgackl, dbgl, owner};

    j_busgnt #(
        .IDLE_HOLD  (4),
        .MAX_TENURE (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mreq   (mreq),
        .dreql  (dreql),
        .ack    (ack),
        .dbrls  (dbrls),
        .bgl    (bgl),
        .bbusyl (bbusyl),
        .brl    (brl),
        .bgackl (bgackl),
        .dbgl   (dbgl),
        .owner  (owner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        mreq = 1'b0; dreql = 1'b1; ack = 1'b0; dbrls = 2'b11;
        bgl = 1'b1; bbusyl = 1'b1; reset = 1'b0;
    endtask

    task automatic to_own(input string tag);
        mreq = 1'b1;
        tick();
        bgl = 1'b0;
        tick();
        tick();
        total++;
        if (outs !== O_OWN) begin
            $display("FAIL %s_enter_own got=%b want=%b", tag, outs, O_OWN);
            bad++;
        end
    endtask

    task automatic test_reset();
        quiet();
        mreq = 1'b1; reset = 1'b1;
        tick();
        total++;
        if (outs !== O_IDLE) begin
            $display("FAIL reset_outs got=%b want=%b", outs, O_IDLE); bad++;
        end
        reset = 1'b0;
        tick();
        total++;
        if (outs !== O_REQ) begin
            $display("FAIL reset_first_req got=%b want=%b", outs, O_REQ); bad++;
        end
        mreq = 1'b0;
        tick();
        total++;
        if (outs !== O_IDLE) begin
            $display("FAIL req_withdraw got=%b want=%b", outs, O_IDLE); bad++;
        end
    endtask

    task automatic test_idle_release();
        quiet();
        mreq = 1'b1;
        tick();
        bgl = 1'b0;
        tick();
        total++;
        if (outs !== O_REQ) begin
            $display("FAIL idle_waitfree got=%b want=%b", outs, O_REQ); bad++;
        end
        tick();
        total++;
        if (outs !== O_OWN) begin
            $display("FAIL idle_own got=%b want=%b", outs, O_OWN); bad++;
        end
        mreq = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (outs !== O_OWN) begin
                $display("FAIL idle_hold_%0d got=%b want=%b", i, outs, O_OWN); bad++;
            end
        end
        tick();
        total++;
        if (outs !== O_REL) begin
            $display("FAIL idle_release got=%b want=%b", outs, O_REL); bad++;
        end
        bgl = 1'b1;
        tick();
        total++;
        if (outs !== O_IDLE) begin
            $display("FAIL idle_after_release got=%b want=%b", outs, O_IDLE); bad++;
        end
    endtask

    task automatic test_dreql_hold();
        quiet();
        to_own("hold");
        mreq = 1'b0; dreql = 1'b0; bgl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (outs !== O_OWN) begin
                $display("FAIL hold_inflight_%0d got=%b want=%b", i, outs, O_OWN); bad++;
            end
        end
        dreql = 1'b1;
        tick();
        total++;
        if (outs !== O_REL) begin
            $display("FAIL hold_deferred_release got=%b want=%b", outs, O_REL); bad++;
        end
        tick();
        total++;
        if (outs !== O_IDLE) begin
            $display("FAIL hold_idle got=%b want=%b", outs, O_IDLE); bad++;
        end
    endtask

    task automatic test_waitfree();
        quiet();
        mreq = 1'b1;
        tick();
        bgl = 1'b0; bbusyl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (outs !== O_REQ) begin
                $display("FAIL waitfree_busy_%0d got=%b want=%b", i, outs, O_REQ); bad++;
            end
        end
        bbusyl = 1'b1;
        tick();
        total++;
        if (outs !== O_OWN) begin
            $display("FAIL waitfree_own got=%b want=%b", outs, O_OWN); bad++;
        end
        mreq = 1'b0; bgl = 1'b1;
        tick();
        total++;
        if (outs !== O_REL) begin
            $display("FAIL waitfree_revoke got=%b want=%b", outs, O_REL); bad++;
        end
        tick();
    endtask

    task automatic test_tenure();
        quiet();
        to_own("ten11");
`ifdef J_BUSGNT_TENURE_EN
        for (int j = 1; j <= 7; j++) begin
            tick();
            total++;
            if (outs !== O_OWN) begin
                $display("FAIL tenure_own_%0d got=%b want=%b", j, outs, O_OWN); bad++;
            end
        end
        tick();
        total++;
        if (outs !== O_REL) begin
            $display("FAIL tenure_release got=%b want=%b", outs, O_REL); bad++;
        end
        tick();
        total++;
        if (outs !== O_IDLE) begin
            $display("FAIL tenure_no_bypass got=%b want=%b", outs, O_IDLE); bad++;
        end
        tick();
        total++;
        if (outs !== O_REQ) begin
            $display("FAIL tenure_rerequest got=%b want=%b", outs, O_REQ); bad++;
        end
        tick();
        tick();
        dbrls = 2'b00;
        total++;
        if (outs !== O_OWN) begin
            $display("FAIL tenure_top_enter got=%b want=%b", outs, O_OWN); bad++;
        end
`endif
        for (int j = 1; j <= 20; j++) begin
            tick();
            total++;
            if (outs !== O_OWN) begin
                $display("FAIL tenure_keep_%0d got=%b want=%b", j, outs, O_OWN); bad++;
            end
        end
        mreq = 1'b0; bgl = 1'b1;
        tick();
        total++;
        if (outs !== O_REL) begin
            $display("FAIL tenure_end got=%b want=%b", outs, O_REL); bad++;
        end
        tick();
    endtask

    task automatic test_grant_wins();
        quiet();
        mreq = 1'b1;
        tick();
        mreq = 1'b0; bgl = 1'b0;
        tick();
        total++;
        if (outs !== O_REQ) begin
            $display("FAIL grant_wins got=%b want=%b", outs, O_REQ); bad++;
        end
        tick();
        total++;
        if (outs !== O_OWN) begin
            $display("FAIL grant_wins_own got=%b want=%b", outs, O_OWN); bad++;
        end
        bgl = 1'b1;
        tick();
        tick();
        mreq = 1'b1;
        tick();
        mreq = 1'b0;
        tick();
        total++;
        if (outs !== O_IDLE) begin
            $display("FAIL withdraw_idle got=%b want=%b", outs, O_IDLE); bad++;
        end
    endtask

    task automatic test_reset_in_own();
        quiet();
        to_own("rst");
        dreql = 1'b0; reset = 1'b1;
        tick();
        total++;
        if (outs !== O_IDLE) begin
            $display("FAIL reset_in_own got=%b want=%b", outs, O_IDLE); bad++;
        end
        quiet();
        tick();
    endtask

    initial begin
        quiet();
        test_reset();
        test_idle_release();
        test_dreql_hold();
        test_waitfree();
        test_tenure();
        test_grant_wins();
        test_reset_in_own();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
